// File: rtl/pwm_demod.sv
// rtl/pwm_demod.sv - PWM-to-sample demodulator: frame-phase lock, per-frame high count, sample FIFO.
module pwm_demod #(
    parameter int FRAME_LEN  = 255,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm_in,
    input  logic       out_ready,
    input  logic       ovf_clr,
    output logic       out_valid,
    output logic [7:0] out_sample,
    output logic       locked,
    output logic       overflow
);
    localparam int PHW = $clog2(FRAME_LEN);
    localparam int HCW = $clog2(FRAME_LEN + 1);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [PHW-1:0] LAST_PHASE = PHW'(FRAME_LEN - 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    logic           sync1_q, pwm_s_q, pwm_d_q, rise;
    state_t         state_q, state_d;
    logic [PHW-1:0] phase_q, phase_d;
    logic [HCW-1:0] hi_cnt_q, hi_cnt_d;
    logic           miss_q, miss_d, misal_q, misal_d;
    logic           push, frame_bad;
    logic [31:0]    total;
    logic [7:0]     push_data;

    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, pop, full, wr_en, drop;

    assign rise = pwm_s_q & ~pwm_d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            pwm_s_q <= 1'b0;
            pwm_d_q <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            pwm_s_q <= sync1_q;
            pwm_d_q <= pwm_s_q;
        end
    end

    // The current cycle's pwm_s is part of the frame total, so the frame end adds it in here.
    assign total     = 32'(hi_cnt_q) + 32'(pwm_s_q);
    assign push_data = (total > 32'd255) ? 8'hFF : total[7:0];

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        hi_cnt_d  = hi_cnt_q;
        miss_d    = miss_q;
        misal_d   = misal_q;
        push      = 1'b0;
        frame_bad = 1'b0;
        case (state_q)
            SEARCH: begin
                phase_d  = '0;
                hi_cnt_d = '0;
                miss_d   = 1'b0;
                misal_d  = 1'b0;
                if (rise) begin
                    state_d  = LOCKED;
                    phase_d  = PHW'(1);
                    hi_cnt_d = HCW'(1);
                end
            end
            LOCKED: begin
                if (phase_q != LAST_PHASE) begin
                    phase_d  = phase_q + PHW'(1);
                    hi_cnt_d = hi_cnt_q + HCW'(pwm_s_q);
                    if (rise && (phase_q != '0)) misal_d = 1'b1;
                end else begin
                    phase_d   = '0;
                    hi_cnt_d  = '0;
                    misal_d   = 1'b0;
                    frame_bad = misal_q | rise;
                    if (!frame_bad) begin
                        miss_d = 1'b0;
                        push   = 1'b1;
                    end else if (!miss_q) begin
                        miss_d = 1'b1;
                        push   = 1'b1;
                    end else begin
                        miss_d  = 1'b0;
                        state_d = SEARCH;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SEARCH;
            phase_q  <= '0;
            hi_cnt_q <= '0;
            miss_q   <= 1'b0;
            misal_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            hi_cnt_q <= hi_cnt_d;
            miss_q   <= miss_d;
            misal_q  <= misal_d;
        end
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign full      = (count_q == CW'(FIFO_DEPTH));
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign wr_en     = push & (~full | pop);
    assign drop      = push & full & ~pop;
    assign count_d   = count_q + CW'(wr_en) - CW'(pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q    <= count_d;
            overflow_q <= drop | (overflow_q & ~ovf_clr);
        end
    end

    assign out_sample = out_valid ? mem_q[rd_ptr_q] : 8'd0;
    assign locked     = (state_q == LOCKED);
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_pwm_demod.sv
// tb/tb_pwm_demod.sv - directed bench for pwm_demod with a frame-based PWM stream generator.
module tb_pwm_demod;
    logic       clk = 1'b0;
    logic       rst, pwm_in, out_ready, ovf_clr;
    logic       out_valid, locked, overflow;
    logic [7:0] out_sample;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit gen_en = 1'b0;
    int hold   = 0;
    int cur    = 0;
    int gcnt   = 0;
    int duty_q[$];

    always #5 clk = ~clk;

    pwm_demod #(.FRAME_LEN(255), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .pwm_in(pwm_in), .out_ready(out_ready), .ovf_clr(ovf_clr),
        .out_valid(out_valid), .out_sample(out_sample), .locked(locked), .overflow(overflow)
    );

    // Generator: 255-cycle frames, duty taken from duty_q at each frame start, optional low gap before a frame.
    initial begin
        pwm_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!gen_en) begin
                pwm_in = 1'b0;
                gcnt   = 0;
            end else if (gcnt == 0 && hold > 0) begin
                pwm_in = 1'b0;
                hold   = hold - 1;
            end else begin
                if (gcnt == 0 && duty_q.size() > 0) cur = duty_q.pop_front();
                pwm_in = (gcnt < cur);
                gcnt   = (gcnt == 254) ? 0 : gcnt + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        cyc = cyc + 1;
        #3;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        n_checks = n_checks + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic get_sample(input string tag, output int val, output int at);
        int n = 0;
        val = -1;
        at  = -1;
        while (!out_valid && n < 600) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, out_valid, 1);
        if (out_valid) begin
            val = out_sample;
            at  = cyc;
            tick();
        end
    endtask

    initial begin
        int t0, v, at, prev, c10, p_cyc, a50, vcount, n, g90, d_cyc;
        rst = 1'b1; out_ready = 1'b1; ovf_clr = 1'b0;
        tick(); tick(); tick();
        check("rst_valid", out_valid, 0);
        check("rst_sample", out_sample, 0);
        check("rst_locked", locked, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;
        tick();

        // Steady duty 100
        duty_q.push_back(100);
        gen_en = 1'b1;
        t0 = cyc;
        tick(); tick(); tick();
        check("lock_before", locked, 0);
        tick();
        check("lock_after", locked, 1);
        prev = 0;
        for (int i = 0; i < 10; i++) begin
            get_sample("steady", v, at);
            check("steady_val", v, 100);
            if (i == 0) check("first_latency", at - t0, 258);
            else        check("spacing", at - prev, 255);
            prev = at;
            if (i == 8) for (int d = 1; d <= 6; d++) duty_q.push_back(d);
        end
        c10 = prev;
        out_ready = 1'b0;

        // Backpressure: duties 1..6
        wait_until(c10 + 4 * 255 + 1);
        check("bp_valid", out_valid, 1);
        check("bp_head", out_sample, 1);
        check("bp_no_ovf", overflow, 0);
        wait_until(c10 + 5 * 255 - 1);
        check("bp_ovf_pre", overflow, 0);
        wait_until(c10 + 5 * 255);
        check("bp_ovf_set", overflow, 1);
        check("bp_head_stable", out_sample, 1);
        wait_until(c10 + 6 * 255 + 5);
        for (int d = 11; d <= 16; d++) duty_q.push_back(d);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            get_sample("bp_drain", v, at);
            check("bp_drain_val", v, i);
        end
        check("bp_empty", out_valid, 0);
        check("bp_ovf_held", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("bp_ovf_clr", overflow, 0);
        out_ready = 1'b0;

        // Simultaneous push/pop while full: FIFO holds 6,11,12,13 when 14 arrives
        p_cyc = c10 + 11 * 255;
        wait_until(p_cyc - 1);
        check("full_head", out_sample, 6);
        check("full_ovf", overflow, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pp_ovf", overflow, 0);
        check("pp_head", out_sample, 11);
        wait_until(p_cyc + 255);
        check("pp_still_full", overflow, 1);
        out_ready = 1'b1;
        for (int i = 11; i <= 14; i++) begin
            get_sample("pp_drain", v, at);
            check("pp_drain_val", v, i);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("pp_ovf_clr", overflow, 0);

        // Phase jump of 37 cycles
        get_sample("pj_pre", v, at);
        check("pj_pre_val", v, 16);
        hold = 37;
        duty_q.push_back(50); duty_q.push_back(60);
        duty_q.push_back(70); duty_q.push_back(80);
        get_sample("pj_pre2", v, at);
        check("pj_pre2_val", v, 16);
        get_sample("pj_mis1", v, a50);
        check("pj_mis1_val", v, 50);
        check("pj_mis1_locked", locked, 1);
        vcount = 0;
        n = 0;
        while (locked && n < 400) begin
            if (out_valid) vcount++;
            tick();
            n++;
        end
        check("pj_unlock", locked, 0);
        check("pj_unlock_time", cyc - a50, 255);
        check("pj_no_sample", vcount, 0);
        get_sample("pj_relock", v, at);
        check("pj_relock_val", v, 70);
        check("pj_relock_locked", locked, 1);
        get_sample("pj_next", v, at);
        check("pj_next_val", v, 80);

        // Extreme duty
        for (int i = 0; i < 5; i++) duty_q.push_back(0);
        for (int i = 0; i < 5; i++) duty_q.push_back(255);
        duty_q.push_back(90);
        get_sample("ex_lead", v, at);
        check("ex_lead_val", v, 80);
        for (int i = 0; i < 5; i++) begin
            get_sample("ex_zero", v, at);
            check("ex_zero_val", v, 0);
            check("ex_zero_locked", locked, 1);
        end
        for (int i = 0; i < 5; i++) begin
            get_sample("ex_one", v, at);
            check("ex_one_val", v, 255);
            check("ex_one_locked", locked, 1);
        end
        get_sample("ex_back", v, g90);
        check("ex_back_val", v, 90);
        out_ready = 1'b0;

        // Reset mid-frame with two entries buffered
        d_cyc = g90 + 510;
        wait_until(d_cyc + 1);
        check("mr_valid_pre", out_valid, 1);
        check("mr_head_pre", out_sample, 90);
        wait_until(d_cyc + 150);
        check("mr_locked_pre", locked, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mr_valid", out_valid, 0);
        check("mr_locked", locked, 0);
        check("mr_overflow", overflow, 0);
        check("mr_sample", out_sample, 0);
        wait_until(d_cyc + 160);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("mr_search", locked, 0);
        vcount = 0;
        n = 0;
        while (!locked && n < 400) begin
            if (out_valid) vcount++;
            tick();
            n++;
        end
        check("mr_relock", locked, 1);
        check("mr_no_sample", vcount, 0);
        get_sample("mr_first", v, at);
        check("mr_first_val", v, 90);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
